// File: rtl/product_accumulator_if.sv
// Valid/ready bundle between the multiplier stage, the product accumulator and its consumer.
// The master modport is the upstream and downstream side. The slave modport is the accumulator itself.
interface product_accumulator_if #(
  parameter int PROD_W = 4,
  parameter int ACC_W  = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_overflow;

  modport master (
    output in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, out_overflow
  );

  modport slave (
    input  in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, out_overflow
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums COUNT unsigned products per frame into a saturating ACC_W-bit result.
// Each completed frame is held on a valid/ready output until it is taken.
module product_accumulator #(
  parameter int PROD_W = 4,
  parameter int COUNT  = 8,
  parameter int ACC_W  = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  product_accumulator_if.slave bus
);
  localparam int CNT_W = (COUNT > 2) ? $clog2(COUNT) : 1;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [ACC_W-1:0]   out_sum_q;
  logic               out_overflow_q;

  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   sat;
  logic               accept;
  logic               last_beat;

  always_comb begin
    sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.in_product};
    if (sum[ACC_W]) sat = '1;
    else            sat = sum[ACC_W-1:0];
    accept    = bus.in_valid && in_ready_q;
    last_beat = (cnt == CNT_W'(COUNT - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ACCUM;
      acc            <= '0;
      cnt            <= '0;
      ovf            <= 1'b0;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_sum_q      <= '0;
      out_overflow_q <= 1'b0;
    end else if (clear) begin
      // Result registers are left alone; they are don't-care while out_valid is low.
      state       <= ACCUM;
      acc         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (last_beat) begin
              out_sum_q      <= sat;
              out_overflow_q <= ovf | sum[ACC_W];
              state          <= HOLD;
              in_ready_q     <= 1'b0;
              out_valid_q    <= 1'b1;
            end else begin
              acc <= sat;
              cnt <= cnt + 1'b1;
              ovf <= ovf | sum[ACC_W];
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= ACCUM;
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= ACCUM;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_sum      = out_sum_q;
  assign bus.out_overflow = out_overflow_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: a table of frames is checked through a result scoreboard.
// Hand-written sequences cover backpressure, clear and reset corner cases.
module tb_product_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  product_accumulator_if #(.PROD_W(4), .ACC_W(6)) bus ();

  product_accumulator #(.PROD_W(4), .COUNT(8), .ACC_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  p [8];
    int unsigned gap;
    logic [5:0]  sum;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [5:0] sum;
    logic       ovf;
  } res_t;

  vec_t vecs [8];
  res_t sb [$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic put_beat(input logic [3:0] p);
    int unsigned n = 0;
    bus.in_valid   = 1'b1;
    bus.in_product = p;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        check("in_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Drives one frame and queues its expected result; post=1 also checks single-cycle out_valid.
  task automatic run_frame(input vec_t v, input bit post);
    res_t r;
    r.sum = v.sum;
    r.ovf = v.ovf;
    sb.push_back(r);
    for (int i = 0; i < 8; i++) begin
      put_beat(v.p[i]);
      if (i < 7) begin
        repeat (v.gap) @(posedge clk);
        if (v.gap > 0) #1;
      end
    end
    if (post) begin
      check("out_valid_after_last", int'(bus.out_valid), 1);
      check("in_ready_in_hold", int'(bus.in_ready), 0);
      @(posedge clk);
      #1;
      check("out_valid_one_cycle", int'(bus.out_valid), 0);
      check("in_ready_returns", int'(bus.in_ready), 1);
    end
  endtask

  function automatic vec_t mkv(input logic [3:0] a, b, c, d, e, f, g, h,
                               input int unsigned gap, input logic [5:0] s, input logic o);
    vec_t v;
    v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = d;
    v.p[4] = e; v.p[5] = f; v.p[6] = g; v.p[7] = h;
    v.gap = gap;
    v.sum = s;
    v.ovf = o;
    return v;
  endfunction

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_product = '0;
    bus.out_ready  = 1'b1;

    vecs[0] = mkv(4'd0, 4'd2, 4'd6, 4'd9, 4'd4, 4'd1, 4'd3, 4'd0, 0, 6'd25, 1'b0);
    vecs[1] = mkv(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 0, 6'd63, 1'b1);
    vecs[2] = mkv(4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 0, 6'd8,  1'b0);
    vecs[3] = mkv(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 0, 6'd0,  1'b0);
    vecs[4] = mkv(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd0, 0, 6'd63, 1'b0);
    vecs[5] = mkv(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd1, 0, 6'd63, 1'b1);
    vecs[6] = mkv(4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 0, 6'd63, 1'b1);
    vecs[7] = mkv(4'd7, 4'd3, 4'd5, 4'd2, 4'd8, 4'd6, 4'd1, 4'd4, 1, 6'd36, 1'b0);

    // Scoreboard consumer: a result is taken when out_valid and out_ready coincide.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            res_t r;
            r = sb.pop_front();
            check("out_sum", int'(bus.out_sum), int'(r.sum));
            check("out_overflow", int'(bus.out_overflow), int'(r.ovf));
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out_sum", int'(bus.out_sum), 0);
    check("reset_out_overflow", int'(bus.out_overflow), 0);
    check("reset_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_frame(vecs[i], 1'b1);

    // Backpressure with bubbles: hold the result and offer beats that must be ignored
    bus.out_ready = 1'b0;
    run_frame(mkv(4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 2, 6'd32, 1'b0), 1'b0);
    bus.in_valid   = 1'b1;
    bus.in_product = 4'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_out_valid", int'(bus.out_valid), 1);
      check("hold_out_sum", int'(bus.out_sum), 32);
      check("hold_in_ready", int'(bus.in_ready), 0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", int'(bus.in_ready), 1);
    check("release_out_valid", int'(bus.out_valid), 0);
    run_frame(vecs[2], 1'b1);

    // Clear mid-frame drops the partial frame and the simultaneous beat
    for (int i = 0; i < 3; i++) put_beat(4'd9);
    bus.in_valid   = 1'b1;
    bus.in_product = 4'd9;
    clear          = 1'b1;
    @(posedge clk);
    #1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    check("clear_out_valid", int'(bus.out_valid), 0);
    check("clear_in_ready", int'(bus.in_ready), 1);
    run_frame(vecs[2], 1'b1);

    // Clear while holding a result discards it
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) put_beat(4'd3);
    check("pending_out_valid", int'(bus.out_valid), 1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clear_hold_out_valid", int'(bus.out_valid), 0);
    check("clear_hold_in_ready", int'(bus.in_ready), 1);

    // Reset while holding a result discards it
    for (int i = 0; i < 8; i++) put_beat(4'd5);
    check("pending2_out_valid", int'(bus.out_valid), 1);
    check("pending2_out_sum", int'(bus.out_sum), 40);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_hold_out_valid", int'(bus.out_valid), 0);
    check("rst_hold_out_sum", int'(bus.out_sum), 0);
    check("rst_hold_in_ready", int'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    run_frame(mkv(4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 0, 6'd16, 1'b0), 1'b1);

    begin
      int unsigned n = 0;
      while (sb.size() != 0 && n < 40) begin
        @(posedge clk);
        n++;
      end
      check("scoreboard_drained", sb.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/product_accumulator.md
# product_accumulator

Frame-based accumulator that consumes the 4-bit product stream from the 2-bit multiplier stage and sums a fixed number of products into one result. It sits directly downstream of the multiplier: upstream logic presents each multiplier product on a valid/ready input, and the block emits one saturated sum per frame on a valid/ready output. Typical use is dot-product style reduction of 2-bit operand pairs.

## Interface

Parameters:
- `PROD_W`, default 4: input product width; matches the multiplier output.
- `COUNT`, default 8: products per frame; must be ≥ 2.
- `ACC_W`, default 6: accumulator and result width; must be ≥ `PROD_W`.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `clear`  input  1  synchronous abort of the current frame.
- `in_valid`  input  1  `in_product` is valid.
- `in_ready`  output  1  block accepts a product this cycle.
- `in_product`  input  `PROD_W`  unsigned product, 0..9 from the 2-bit multiplier.
- `out_valid`  output  1  `out_sum` and `out_overflow` hold a completed frame.
- `out_ready`  input  1  downstream accepts the result.
- `out_sum`  output  `ACC_W`  saturated frame sum.
- `out_overflow`  output  1  the frame sum exceeded 2^`ACC_W` − 1.

## Operation

- FSM states: ACCUM and HOLD.
- Reset (`rst_n`=0 at a clock edge): state goes to ACCUM. Accumulator, beat counter, `out_sum` and `out_overflow` all go to 0. `out_valid`=0. `in_ready` is 1 from the first cycle after reset.
- ACCUM:
  - `in_ready`=1 and `out_valid`=0.
  - A beat is accepted on `in_valid && in_ready`.
  - Each accepted beat sets acc ← sat(acc + `in_product`) and cnt ← cnt+1.
  - `ovf` becomes sticky-set if the unsaturated sum is greater than 2^`ACC_W` − 1.
  - On the beat where cnt = `COUNT`−1: latch `out_sum` = sat(acc + product) and `out_overflow` = the sticky `ovf` including this beat, then move to HOLD.
- HOLD:
  - `in_ready`=0 and `out_valid`=1.
  - `out_sum` and `out_overflow` stay stable until the handshake.
  - On `out_valid && out_ready`: move to ACCUM and reset acc, cnt and `ovf` to 0.
- Arithmetic:
  - Unsigned throughout.
  - The sum is computed at `ACC_W`+1 bits.
  - Saturation clamps to all-ones in `ACC_W` bits.
- `clear`:
  - Highest priority after reset.
  - In any state it sets acc, cnt, `ovf` and `out_valid` to 0 and moves to ACCUM.
  - A beat offered in the same cycle as `clear` is dropped and not counted.
  - `out_sum` and `out_overflow` keep their last values but are meaningless while `out_valid`=0.
- Input bubbles: `in_valid`=0 cycles do not advance cnt, and the frame may span any number of cycles.
- `in_product` values above 9 are accumulated as given, with no range check.

## Timing

- `in_ready` and `out_valid` are registered state decodes, with no combinational path from `in_valid` or `out_ready`.
- Latency: `out_valid` rises on the clock edge that accepts the last beat, so it is visible in the following cycle.
- Throughput:
  - With back-to-back input and `out_ready`=1, a frame takes `COUNT` accept cycles plus 1 HOLD cycle.
  - Default parameters give 9 cycles per frame.
- Output handshake completes in the cycle `out_valid && out_ready`. `in_ready` returns to 1 in the next cycle.
- Holding `out_ready`=0 keeps the block in HOLD indefinitely with outputs frozen and `in_ready`=0.
- Reset or `clear` asserted mid-frame or in HOLD takes effect at that edge, and the partial or pending frame is discarded.
- Simultaneous `rst_n`=0 and `clear`=1: reset wins, with an identical outcome.

## Test plan

All scenarios use default parameters (`COUNT`=8, `ACC_W`=6).

- Reset: hold `rst_n`=0 for 2 cycles, then release → `out_valid`=0, `out_sum`=0, `out_overflow`=0, `in_ready`=1.
- Normal frame: products 0,2,6,9,4,1,3,0 back-to-back with `out_ready`=1 → `out_valid` for 1 cycle, `out_sum`=25, `out_overflow`=0, frame completes in 9 cycles.
- Saturation: eight products of 9 (sum 72) → `out_sum`=63 and `out_overflow`=1. The next frame of eight 1s gives `out_sum`=8 and `out_overflow`=0, confirming the sticky flag clears between frames.
- Backpressure and bubbles:
  - Insert `in_valid`=0 gaps between beats of 4,4,4,4,4,4,4,4 → `out_sum`=32.
  - Hold `out_ready`=0 for 3 cycles → `out_valid`=1, `out_sum` stable at 32, `in_ready`=0 throughout.
  - Beats offered during HOLD are not accepted.
- Clear mid-frame:
  - Accept 9,9,9, then pulse `clear` together with a valid 9 → that beat is dropped.
  - The following frame of 1,1,1,1,1,1,1,1 gives `out_sum`=8.
- Reset in HOLD: drive `rst_n`=0 while `out_valid`=1 → `out_valid`=0 in the next cycle, and a fresh frame of eight 2s gives `out_sum`=16.
